// File: rtl/axi4_lite_read_slave_mem_pkg.sv
// Shared read-slave types: response encoding, delay width and the memory slave FSM states.
package axi4_lite_read_slave_mem_pkg;

    localparam int unsigned DELAY_WIDTH = 5;

    typedef enum logic [1:0] {
        READ_OKAY   = 2'b00,
        READ_EXOKAY = 2'b01,
        READ_SLVERR = 2'b10,
        READ_DECERR = 2'b11
    } rrespEnum;

    typedef enum logic [2:0] {
        IDLE,
        AR_DELAY,
        AR_READY,
        R_DELAY,
        R_VALID
    } axi4LiteReadSlaveMemStateEnum;

endpackage

// File: rtl/axi4_lite_read_slave_mem_if.sv
// AXI4-Lite read address and read data channels.
interface axi4_lite_read_slave_mem_if
    import axi4_lite_read_slave_mem_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH = 32,
    parameter int unsigned DATA_WIDTH    = 32
) ();

    logic [ADDRESS_WIDTH-1:0] araddr;
    logic [2:0]               arprot;
    logic                     arvalid;
    logic                     arready;
    logic [DATA_WIDTH-1:0]    rdata;
    rrespEnum                 rresp;
    logic                     rvalid;
    logic                     rready;

    modport master (
        output araddr, arprot, arvalid, rready,
        input  arready, rdata, rresp, rvalid
    );

    modport slave (
        input  araddr, arprot, arvalid, rready,
        output arready, rdata, rresp, rvalid
    );

endinterface

// File: rtl/axi4_lite_delay_counter.sv
// Loadable down-counter; done flags the last cycle of a programmed delay.
module axi4_lite_delay_counter #(
    parameter int unsigned WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] loadValue,
    input  logic             dec,
    output logic             done
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= loadValue;
        end else if (dec && count_q != '0) begin
            count_q <= count_q - WIDTH'(1);
        end
    end

    assign done = (count_q == WIDTH'(1));

endmodule

// File: rtl/axi4_lite_read_slave_mem.sv
// AXI4-Lite read slave backed by a word memory, with programmable arready/rvalid delays.
module axi4_lite_read_slave_mem #(
    parameter int unsigned              ADDRESS_WIDTH = 32,
    parameter int unsigned              DATA_WIDTH    = 32,
    parameter int unsigned              DELAY_WIDTH   = axi4_lite_read_slave_mem_pkg::DELAY_WIDTH,
    parameter logic [ADDRESS_WIDTH-1:0] MIN_ADDRESS   = 'h01,
    parameter logic [ADDRESS_WIDTH-1:0] MAX_ADDRESS   = 'hff,
    parameter int unsigned              MEM_DEPTH     = 64,
    parameter bit                       DEFAULT_READY = 1'b0
) (
    input  logic                         aclk,
    input  logic                         aresetn,
    axi4_lite_read_slave_mem_if.slave    bus,
    input  logic [DELAY_WIDTH-1:0]       delayForArready,
    input  logic [DELAY_WIDTH-1:0]       delayForRvalid,
    input  logic                         memWrEn,
    input  logic [$clog2(MEM_DEPTH)-1:0] memWrIdx,
    input  logic [DATA_WIDTH-1:0]        memWrData
);
    import axi4_lite_read_slave_mem_pkg::*;

    localparam int unsigned OFFSET_BITS = $clog2(DATA_WIDTH / 8);
    localparam int unsigned IDX_WIDTH   = $clog2(MEM_DEPTH);

    axi4LiteReadSlaveMemStateEnum state_q, state_d;
    logic                  arready_q, arready_d;
    logic                  rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    rrespEnum              rresp_q, rresp_d;
    logic [2:0]            arprot_q;
    logic                  unused_arprot;

    logic                   cnt_load, cnt_dec, cnt_done;
    logic [DELAY_WIDTH-1:0] cnt_value;
    logic                   ar_hs, r_hs;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
    logic [IDX_WIDTH-1:0]  rd_idx;

    assign ar_hs  = bus.arvalid && arready_q;
    assign r_hs   = rvalid_q && bus.rready;
    assign rd_idx = bus.araddr[OFFSET_BITS +: IDX_WIDTH];

    axi4_lite_delay_counter #(
        .WIDTH(DELAY_WIDTH)
    ) u_delay_counter (
        .clk      (aclk),
        .rst_n    (aresetn),
        .load     (cnt_load),
        .loadValue(cnt_value),
        .dec      (cnt_dec),
        .done     (cnt_done)
    );

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= IDLE;
            arready_q <= DEFAULT_READY;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= READ_OKAY;
            arprot_q  <= '0;
        end else begin
            state_q   <= state_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            if (ar_hs) arprot_q <= bus.arprot;
        end
    end

    // No reset: contents survive an aresetn pulse.
    always_ff @(posedge aclk) begin
        if (memWrEn) mem[memWrIdx] <= memWrData;
    end

    always_comb begin
        state_d   = state_q;
        cnt_load  = 1'b0;
        cnt_value = '0;
        cnt_dec   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!DEFAULT_READY && bus.arvalid) begin
                    if (delayForArready == '0) begin
                        state_d = AR_READY;
                    end else begin
                        cnt_load  = 1'b1;
                        cnt_value = delayForArready;
                        state_d   = AR_DELAY;
                    end
                end
            end
            AR_DELAY: begin
                cnt_dec = 1'b1;
                if (cnt_done) state_d = AR_READY;
            end
            AR_READY: ;
            R_DELAY: begin
                cnt_dec = 1'b1;
                if (cnt_done) state_d = R_VALID;
            end
            R_VALID: begin
                if (r_hs) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // The AR handshake can complete in IDLE (default-ready) or in AR_READY.
        if (ar_hs) begin
            cnt_dec = 1'b0;
            if (delayForRvalid == '0) begin
                state_d = R_VALID;
            end else begin
                cnt_load  = 1'b1;
                cnt_value = delayForRvalid;
                state_d   = R_DELAY;
            end
        end
    end

    // Next values of the registered outputs; arready/rvalid lag their state by one edge.
    always_comb begin
        arready_d = 1'b0;
        rvalid_d  = (state_q == R_VALID) && !r_hs;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        if (!ar_hs) begin
            unique case (state_q)
                IDLE:     arready_d = DEFAULT_READY;
                AR_READY: arready_d = 1'b1;
                R_VALID:  arready_d = r_hs ? DEFAULT_READY : 1'b0;
                default:  arready_d = 1'b0;
            endcase
        end
        if (ar_hs) begin
            if (bus.araddr < MIN_ADDRESS || bus.araddr > MAX_ADDRESS) begin
                rresp_d = READ_DECERR;
                rdata_d = '0;
            end else if (bus.araddr[OFFSET_BITS-1:0] != '0) begin
                rresp_d = READ_SLVERR;
                rdata_d = '0;
            end else begin
                rresp_d = READ_OKAY;
                rdata_d = mem[rd_idx];
            end
        end
    end

    assign unused_arprot = ^arprot_q;

    assign bus.arready = arready_q;
    assign bus.rvalid  = rvalid_q;
    assign bus.rdata   = rdata_q;
    assign bus.rresp   = rresp_q;

endmodule
